// File: rtl/clock_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// clock_ctrl_fsm
// Front-panel controller for the digital clock time datapath. Six raw
// push-buttons are synchronised and debounced; their debounced press events
// drive a mode state machine that produces the datapath control signals.
// All logic runs in the 1 MHz datapath clock domain.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   btn_mode   in   raw button: step through the set modes
//   btn_up     in   raw button: increment (auto-repeats while held)
//   btn_down   in   raw button: decrement (auto-repeats while held)
//   btn_sw     in   raw button: enter/leave stopwatch
//   btn_hold   in   raw button: toggle stopwatch hold
//   btn_zone   in   raw button: cycle the time zone
//   mode[1:0]  out  00 run, 01 set hour, 10 set min, 11 set sec
//   increment  out  single-cycle increment pulse
//   decrement  out  single-cycle decrement pulse
//   stp        out  timekeeping stopped for setting
//   stpw       out  stopwatch display/run
//   hold       out  stopwatch frozen
//   USA/ENG/CHA/CAL out  one-hot zone select, all zero = local time
// -----------------------------------------------------------------------------
module clock_ctrl_fsm #(
    parameter int DEB_CYCLES   = 20000,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000,
    parameter int CW           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sw,
    input  logic       btn_hold,
    input  logic       btn_zone,
    output logic [1:0] mode,
    output logic       increment,
    output logic       decrement,
    output logic       stp,
    output logic       stpw,
    output logic       hold,
    output logic       USA,
    output logic       ENG,
    output logic       CHA,
    output logic       CAL
);

    // Button index within the packed button vectors
    localparam int BM = 0;
    localparam int BU = 1;
    localparam int BD = 2;
    localparam int BS = 3;
    localparam int BH = 4;
    localparam int BZ = 5;

    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        S_CLOCK,
        S_SET_H,
        S_SET_M,
        S_SET_S,
        S_STOPWATCH
    } state_e;

    // ------------------------------------------------------------------
    // Input path: 2-flop synchroniser + per-button debounce counter
    // ------------------------------------------------------------------
    logic [5:0]    btn_raw;
    logic [5:0]    sync1_q, sync2_q;
    logic [5:0]    deb_q, deb_d, deb_prev_q;
    logic [CW-1:0] deb_cnt_q [6];
    logic [CW-1:0] deb_cnt_d [6];
    logic [5:0]    press;

    assign btn_raw = {btn_zone, btn_hold, btn_sw, btn_down, btn_up, btn_mode};

    // NOTE: every variable written in an always_comb gets a default at the top,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            // The counter only runs while the synced level disagrees with the
            // debounced one; any agreement restarts the stability window.
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // One-cycle event while the debounced level has just gone high
    assign press = deb_q & ~deb_prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            // NOTE: the debounce counters are real state and must start from
            // zero, so this small array is reset like any other register.
            for (int i = 0; i < 6; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 6; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode state machine
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    logic   state_change;
    logic   in_set;

    always_comb begin
        state_d = state_q;
        case (state_q)
            // mode has priority over sw when both arrive together
            S_CLOCK: begin
                if (press[BM])      state_d = S_SET_H;
                else if (press[BS]) state_d = S_STOPWATCH;
            end
            S_SET_H:     if (press[BM]) state_d = S_SET_M;
            S_SET_M:     if (press[BM]) state_d = S_SET_S;
            S_SET_S:     if (press[BM]) state_d = S_CLOCK;
            S_STOPWATCH: if (press[BM] || press[BS]) state_d = S_CLOCK;
            default:     state_d = S_CLOCK;
        endcase
    end

    assign state_change = (state_d != state_q);
    assign in_set       = (state_q == S_SET_H) || (state_q == S_SET_M) ||
                          (state_q == S_SET_S);

    // ------------------------------------------------------------------
    // Increment/decrement with auto-repeat (index 0 = up, 1 = down)
    // ------------------------------------------------------------------
    logic [CW-1:0] rep_cnt_q [2];
    logic [CW-1:0] rep_cnt_d [2];
    logic [1:0]    rep_arm_q, rep_arm_d;   // armed by a press in SET_x
    logic [1:0]    rep_ph_q, rep_ph_d;     // 0 = initial delay, 1 = repeat rate
    logic [1:0]    pulse;
    logic          both_held;

    assign both_held = deb_q[BU] & deb_q[BD];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rep_cnt_d[k] = rep_cnt_q[k];
            rep_arm_d[k] = rep_arm_q[k];
            rep_ph_d[k]  = rep_ph_q[k];
            pulse[k]     = 1'b0;
            if (!deb_q[BU + k] || both_held || state_change) begin
                // Disarm: a fresh release + press is needed to start again
                rep_cnt_d[k] = '0;
                rep_arm_d[k] = 1'b0;
                rep_ph_d[k]  = 1'b0;
            end else if (press[BU + k] && in_set) begin
                rep_cnt_d[k] = '0;
                rep_arm_d[k] = 1'b1;
                rep_ph_d[k]  = 1'b0;
                pulse[k]     = 1'b1;
            end else if (rep_arm_q[k]) begin
                if (!rep_ph_q[k] && rep_cnt_q[k] == DELAY_LAST) begin
                    rep_cnt_d[k] = '0;
                    rep_ph_d[k]  = 1'b1;
                    pulse[k]     = 1'b1;
                end else if (rep_ph_q[k] && rep_cnt_q[k] == RATE_LAST) begin
                    rep_cnt_d[k] = '0;
                    pulse[k]     = 1'b1;
                end else begin
                    rep_cnt_d[k] = rep_cnt_q[k] + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, computed from the next state
    // ------------------------------------------------------------------
    logic [1:0] mode_q, mode_d;
    logic       stp_q, stp_d;
    logic       stpw_q, stpw_d;
    logic       hold_q, hold_d;
    logic [3:0] zone_q, zone_d;            // {USA, ENG, CHA, CAL}
    logic       inc_q, dec_q;

    always_comb begin
        mode_d = 2'b00;
        stp_d  = 1'b0;
        stpw_d = 1'b0;
        case (state_d)
            S_SET_H:     begin mode_d = 2'b01; stp_d = 1'b1; end
            S_SET_M:     begin mode_d = 2'b10; stp_d = 1'b1; end
            S_SET_S:     begin mode_d = 2'b11; stp_d = 1'b1; end
            S_STOPWATCH: stpw_d = 1'b1;
            default:     ;
        endcase

        // Hold only toggles while staying in the stopwatch and is cleared on
        // the very edge that leaves it.
        hold_d = 1'b0;
        if (state_d == S_STOPWATCH) begin
            hold_d = hold_q ^ ((state_q == S_STOPWATCH) && press[BH]);
        end

        zone_d = zone_q;
        if ((state_q == S_CLOCK) && press[BZ]) begin
            case (zone_q)
                4'b0000: zone_d = 4'b1000;   // LOCAL -> USA
                4'b1000: zone_d = 4'b0100;   // USA   -> ENG
                4'b0100: zone_d = 4'b0010;   // ENG   -> CHA
                4'b0010: zone_d = 4'b0001;   // CHA   -> CAL
                default: zone_d = 4'b0000;   // CAL (or anything else) -> LOCAL
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_CLOCK;
            mode_q    <= 2'b00;
            stp_q     <= 1'b0;
            stpw_q    <= 1'b0;
            hold_q    <= 1'b0;
            zone_q    <= 4'b0000;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            rep_arm_q <= '0;
            rep_ph_q  <= '0;
            for (int k = 0; k < 2; k++) begin
                rep_cnt_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            stp_q     <= stp_d;
            stpw_q    <= stpw_d;
            hold_q    <= hold_d;
            zone_q    <= zone_d;
            inc_q     <= pulse[0];
            dec_q     <= pulse[1];
            rep_arm_q <= rep_arm_d;
            rep_ph_q  <= rep_ph_d;
            for (int k = 0; k < 2; k++) begin
                rep_cnt_q[k] <= rep_cnt_d[k];
            end
        end
    end

    assign mode                = mode_q;
    assign stp                 = stp_q;
    assign stpw                = stpw_q;
    assign hold                = hold_q;
    assign {USA, ENG, CHA, CAL} = zone_q;
    assign increment           = inc_q;
    assign decrement           = dec_q;

endmodule
